// File: rtl/fetch_sequencer_if.sv
// ============================================================================
// Module   : fetch_sequencer_if
// Purpose  : Control, ROM and fetch-stage signal bundle for fetch_sequencer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface fetch_sequencer_if #(
    parameter int AW = 8,
    parameter int DW = 9,
    parameter int CW = 16
);
    logic          Start;
    logic          Stall;
    logic          Halt;
    logic          BranchAbs;
    logic          BranchRel;
    logic [AW-1:0] Target;
    logic [AW-1:0] Offset;
    logic [DW-1:0] InstIn;
    logic [AW-1:0] InstAddress;
    logic [DW-1:0] InstOut;
    logic [AW-1:0] FetchPC;
    logic          InstValid;
    logic          Done;
    logic          PcWrap;
    logic [CW-1:0] CycleCount;

    // Environment side: control inputs and ROM data, observes fetch outputs.
    modport master (
        output Start, Stall, Halt, BranchAbs, BranchRel, Target, Offset, InstIn,
        input  InstAddress, InstOut, FetchPC, InstValid, Done, PcWrap, CycleCount
    );

    modport slave (
        input  Start, Stall, Halt, BranchAbs, BranchRel, Target, Offset, InstIn,
        output InstAddress, InstOut, FetchPC, InstValid, Done, PcWrap, CycleCount
    );
endinterface

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : PC sequencer and fetch register with branch flush and run counter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_sequencer #(
    parameter int AW         = 8,
    parameter int DW         = 9,
    parameter int START_ADDR = 0,
    parameter int CW         = 16
) (
    input  wire logic             CLK,
    input  wire logic             Reset_n,
    fetch_sequencer_if.slave      bus
);
    localparam logic [AW-1:0] c_start_pc = AW'(START_ADDR);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] inst_q, inst_d;
    logic [AW-1:0] fpc_q, fpc_d;
    logic          valid_q, valid_d;
    logic          wrap_q, wrap_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        fpc_d   = fpc_q;
        valid_d = valid_q;
        wrap_d  = wrap_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.Start) begin
                    state_d = RUN;
                    pc_d    = c_start_pc;
                    cnt_d   = '0;
                    wrap_d  = 1'b0;
                end
            end
            RUN: begin
                if (!bus.Stall) begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    // Redirects are only honoured against a live instruction,
                    // so requests seen during the flush bubble fall through.
                    if (valid_q && bus.Halt) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                    end else if (valid_q && bus.BranchAbs) begin
                        pc_d    = bus.Target;
                        valid_d = 1'b0;
                    end else if (valid_q && bus.BranchRel) begin
                        pc_d    = fpc_q + bus.Offset;
                        valid_d = 1'b0;
                    end else begin
                        inst_d  = bus.InstIn;
                        fpc_d   = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_q + 1'b1;
                        if (pc_q == '1) begin
                            wrap_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            pc_q    <= c_start_pc;
            inst_q  <= '0;
            fpc_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            fpc_q   <= fpc_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.InstAddress = pc_q;
    assign bus.InstOut     = inst_q;
    assign bus.FetchPC     = fpc_q;
    assign bus.InstValid   = valid_q;
    assign bus.Done        = (state_q == DONE);
    assign bus.PcWrap      = wrap_q;
    assign bus.CycleCount  = cnt_q;
endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ============================================================================
// Module   : tb_fetch_sequencer
// Purpose  : Directed scoreboard bench for fetch_sequencer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_sequencer;
    localparam int AW = 8;
    localparam int DW = 9;
    localparam int CW = 16;

    logic CLK = 1'b0;
    logic Reset_n;

    fetch_sequencer_if #(.AW(AW), .DW(DW), .CW(CW)) bus ();

    fetch_sequencer #(.AW(AW), .DW(DW), .START_ADDR(0), .CW(CW)) dut (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    // ROM image: word at address a is a+1.
    function automatic logic [DW-1:0] rom_val(input logic [AW-1:0] a);
        return {1'b0, a} + 9'd1;
    endfunction

    assign bus.InstIn = rom_val(bus.InstAddress);

    int              n_cmp = 0;
    int              n_err = 0;
    logic [AW-1:0]   exp_pc;
    logic [CW-1:0]   exp_cnt;
    logic [AW+DW-1:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic tick_run();
        tick();
        exp_cnt = exp_cnt + 1'b1;
    endtask

    // One sequential fetch: expect address exp_pc now, its word one cycle later.
    task automatic seq_step();
        logic [AW+DW-1:0] item;
        chk("addr", 32'(bus.InstAddress), 32'(exp_pc));
        sb.push_back({exp_pc, rom_val(exp_pc)});
        tick_run();
        exp_pc = exp_pc + 1'b1;
        item = sb.pop_front();
        chk("inst", 32'(bus.InstOut), 32'(item[DW-1:0]));
        chk("fpc", 32'(bus.FetchPC), 32'(item[AW+DW-1:DW]));
        chk("valid", 32'(bus.InstValid), 32'd1);
        chk("cnt", 32'(bus.CycleCount), 32'(exp_cnt));
    endtask

    task automatic start_run();
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        exp_pc  = '0;
        exp_cnt = '0;
        chk("start_addr", 32'(bus.InstAddress), 32'd0);
        chk("start_valid", 32'(bus.InstValid), 32'd0);
        chk("start_done", 32'(bus.Done), 32'd0);
        chk("start_cnt", 32'(bus.CycleCount), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_addr"}, 32'(bus.InstAddress), 32'd0);
        chk({tag, "_inst"}, 32'(bus.InstOut), 32'd0);
        chk({tag, "_fpc"}, 32'(bus.FetchPC), 32'd0);
        chk({tag, "_valid"}, 32'(bus.InstValid), 32'd0);
        chk({tag, "_done"}, 32'(bus.Done), 32'd0);
        chk({tag, "_wrap"}, 32'(bus.PcWrap), 32'd0);
        chk({tag, "_cnt"}, 32'(bus.CycleCount), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset_n       = 1'b0;
        bus.Start     = 1'b0;
        bus.Stall     = 1'b0;
        bus.Halt      = 1'b0;
        bus.BranchAbs = 1'b0;
        bus.BranchRel = 1'b0;
        bus.Target    = '0;
        bus.Offset    = '0;
        exp_pc        = '0;
        exp_cnt       = '0;
        tick();
        tick();
        Reset_n = 1'b1;
        check_zero("reset");

        // IDLE ignores everything but Start
        bus.BranchAbs = 1'b1;
        bus.Target    = 8'h33;
        bus.Halt      = 1'b1;
        tick();
        bus.BranchAbs = 1'b0;
        bus.Halt      = 1'b0;
        check_zero("idle");

        // Linear fetch of 0..5
        start_run();
        for (int i = 0; i < 6; i++) seq_step();

        // Absolute branch: fetch of 6 flushed
        chk("pre_abs_addr", 32'(bus.InstAddress), 32'h06);
        bus.BranchAbs = 1'b1;
        bus.Target    = 8'h40;
        tick_run();
        bus.BranchAbs = 1'b0;
        chk("abs_bubble", 32'(bus.InstValid), 32'd0);
        chk("abs_addr", 32'(bus.InstAddress), 32'h40);
        exp_pc = 8'h40;
        seq_step();

        // Relative branch backwards from 0x10
        bus.BranchAbs = 1'b1;
        bus.Target    = 8'h10;
        tick_run();
        bus.BranchAbs = 1'b0;
        exp_pc = 8'h10;
        seq_step();
        bus.BranchRel = 1'b1;
        bus.Offset    = 8'hFE;
        tick_run();
        bus.BranchRel = 1'b0;
        chk("rel_bubble", 32'(bus.InstValid), 32'd0);
        chk("rel_back_addr", 32'(bus.InstAddress), 32'h0E);
        exp_pc = 8'h0E;
        seq_step();

        // Relative branch wrapping modulo 256 does not set PcWrap
        bus.BranchAbs = 1'b1;
        bus.Target    = 8'hFD;
        tick_run();
        bus.BranchAbs = 1'b0;
        exp_pc = 8'hFD;
        seq_step();
        bus.BranchRel = 1'b1;
        bus.Offset    = 8'h05;
        tick_run();
        bus.BranchRel = 1'b0;
        chk("rel_wrap_addr", 32'(bus.InstAddress), 32'h02);
        chk("rel_wrap_flag", 32'(bus.PcWrap), 32'd0);
        exp_pc = 8'h02;

        // Branch during the bubble is ignored
        bus.BranchAbs = 1'b1;
        bus.Target    = 8'h77;
        seq_step();
        bus.BranchAbs = 1'b0;

        // Stall for 3 cycles with Halt pending
        bus.Stall = 1'b1;
        bus.Halt  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_addr", 32'(bus.InstAddress), 32'h03);
            chk("stall_inst", 32'(bus.InstOut), 32'(rom_val(8'h02)));
            chk("stall_fpc", 32'(bus.FetchPC), 32'h02);
            chk("stall_cnt", 32'(bus.CycleCount), 32'(exp_cnt));
            chk("stall_done", 32'(bus.Done), 32'd0);
        end
        bus.Stall = 1'b0;
        tick_run();
        bus.Halt = 1'b0;
        chk("halt_done", 32'(bus.Done), 32'd1);
        chk("halt_valid", 32'(bus.InstValid), 32'd0);
        chk("halt_addr", 32'(bus.InstAddress), 32'h03);
        chk("halt_cnt", 32'(bus.CycleCount), 32'(exp_cnt));
        tick();
        chk("done_hold_cnt", 32'(bus.CycleCount), 32'(exp_cnt));
        chk("done_hold", 32'(bus.Done), 32'd1);

        // Sequential wrap past 0xFF, sticky PcWrap, Start ignored in RUN
        start_run();
        seq_step();
        bus.BranchAbs = 1'b1;
        bus.Target    = 8'hFE;
        tick_run();
        bus.BranchAbs = 1'b0;
        exp_pc = 8'hFE;
        seq_step();
        chk("prewrap_flag", 32'(bus.PcWrap), 32'd0);
        seq_step();
        chk("wrap_addr", 32'(bus.InstAddress), 32'h00);
        chk("wrap_flag", 32'(bus.PcWrap), 32'd1);
        bus.Start = 1'b1;
        seq_step();
        bus.Start = 1'b0;
        chk("wrap_sticky", 32'(bus.PcWrap), 32'd1);
        bus.Halt = 1'b1;
        tick_run();
        bus.Halt = 1'b0;
        chk("wrap_done", 32'(bus.Done), 32'd1);
        chk("wrap_sticky_done", 32'(bus.PcWrap), 32'd1);

        // Restart clears PcWrap; halt after 10 unstalled RUN cycles
        start_run();
        chk("restart_wrap", 32'(bus.PcWrap), 32'd0);
        for (int i = 0; i < 9; i++) seq_step();
        bus.Halt = 1'b1;
        tick_run();
        bus.Halt = 1'b0;
        chk("ten_done", 32'(bus.Done), 32'd1);
        chk("ten_cnt", 32'(bus.CycleCount), 32'd10);
        tick();
        chk("ten_cnt_hold", 32'(bus.CycleCount), 32'd10);

        // Reset from DONE
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        check_zero("rst_done");

        // Reset mid-RUN, also while stalled
        start_run();
        seq_step();
        seq_step();
        bus.Stall = 1'b1;
        Reset_n   = 1'b0;
        tick();
        Reset_n   = 1'b1;
        bus.Stall = 1'b0;
        check_zero("rst_run");

        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Program-counter sequencer and fetch-stage register for the instruction ROM (8-bit address, 9-bit instruction word). It drives the ROM address, captures the combinational ROM output into a fetch register, and handles start/halt, stall, and absolute and relative branch redirects with a one-slot flush. It sits between the ROM and the decode stage, and also keeps a run-cycle counter for the lab's dynamic instruction count.

Parameters:
AW, 8, instruction address width (ROM depth 2^AW)
DW, 9, instruction word width
START_ADDR, 0, PC value loaded on Start
CW, 16, cycle counter width

Ports:
CLK  input  1  clock; all state updates on the rising edge
Reset_n  input  1  synchronous, active-low reset
Start  input  1  one-cycle pulse; begins execution at START_ADDR
Stall  input  1  freezes PC, fetch register and counter while high
Halt  input  1  from decode; ends execution
BranchAbs  input  1  redirect PC to Target
BranchRel  input  1  redirect PC to FetchPC + Offset
Target  input  AW  absolute branch target
Offset  input  AW  two's-complement relative offset
InstIn  input  DW  ROM data for InstAddress (combinational, same cycle)
InstAddress  output  AW  ROM address (equals PC)
InstOut  output  DW  registered fetched instruction
FetchPC  output  AW  address InstOut was fetched from
InstValid  output  1  InstOut is a live instruction
Done  output  1  high in DONE state
PcWrap  output  1  sticky: PC incremented past 2^AW-1
CycleCount  output  CW  cycles spent in RUN (not stalled)

Behaviour:
- States: IDLE, RUN, DONE. Reset (Reset_n=0 at a clock edge): state=IDLE, PC=START_ADDR, InstOut=0, FetchPC=0, InstValid=0, Done=0, PcWrap=0, CycleCount=0. Reset overrides everything, including mid-RUN and during Stall.
- IDLE: outputs hold their reset values. Start=1 -> RUN, PC=START_ADDR, CycleCount=0, PcWrap=0. All other inputs are ignored.
- RUN, Stall=1: all registers hold, including the state. Halt, branch and Start are ignored; decode keeps them asserted until the stall is released.
- RUN, Stall=0, evaluated with priority Halt > BranchAbs > BranchRel > sequential:
  - CycleCount increments every such cycle and saturates at 2^CW-1.
  - Halt (qualified only when InstValid=1): go to DONE. InstValid<=0, PC holds.
  - BranchAbs (qualified when InstValid=1): PC<=Target. InstValid<=0, so the instruction fetched this cycle is flushed.
  - BranchRel (qualified when InstValid=1): PC<=FetchPC+Offset, computed modulo 2^AW (wraps silently; PcWrap not set). InstValid<=0.
  - Sequential: InstOut<=InstIn, FetchPC<=PC, InstValid<=1, PC<=PC+1. If PC was 2^AW-1, PC wraps to 0 and PcWrap<=1.
  - Halt, BranchAbs and BranchRel arriving while InstValid=0 (the flush bubble) are ignored.
- Fetch latency: the instruction at address A appears on InstOut one cycle after InstAddress=A. A taken branch costs one bubble cycle.
- DONE: Done=1. PC, InstOut, FetchPC and CycleCount hold; InstValid=0. Start=1 -> RUN exactly as from IDLE (Done clears).
- Start while in RUN is ignored.
- InstAddress is driven combinationally from the PC register only; it never has a combinational path from any input.

Test Plan:
- Reset then Start, ROM[0..3]=9'h001..9'h004, no stall -> InstAddress 0,1,2,3 on consecutive cycles; InstOut 001..004 with FetchPC 0..3 one cycle later; InstValid=1 from the second RUN cycle.
- BranchAbs with Target=8'h40 while InstOut is the instruction at 5 -> next cycle InstValid=0 (the fetch of address 6 is discarded), InstAddress=0x40; the following cycle InstOut=ROM[0x40], FetchPC=0x40.
- BranchRel with Offset=8'hFE at FetchPC=0x10 -> PC=0x0E after one bubble. With Offset=8'h05 at FetchPC=0xFD -> PC=0x02 and PcWrap stays 0.
- Stall held 3 cycles mid-run -> InstAddress, InstOut, FetchPC and CycleCount unchanged for all 3 cycles; a Halt asserted during the stall is acted on only in the first unstalled cycle.
- Sequential run through address 0xFF -> next InstAddress=0x00, PcWrap=1 and sticky; the next Start clears it.
- Halt after 10 unstalled RUN cycles -> Done=1, CycleCount=10 and holding. Reset_n=0 in DONE -> IDLE, all outputs zero. Reset_n=0 mid-RUN -> IDLE on that edge.
